// File: rtl/tone_pkg.sv
// tone_pkg: shared constants and state type for the tone generator.
//   CLK_HZ         system clock frequency
//   HALF_DIVIDEND  clock cycles per second divided by two (one half-period per Hz)
//   FREQ_W         width of the Hz request
//   HW             half-period / quotient width; 2^HW must exceed HALF_DIVIDEND
//   MIN_HZ/MAX_HZ  playable range; requests outside it are silence
package tone_pkg;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned HALF_DIVIDEND = CLK_HZ / 2;
    localparam int unsigned FREQ_W        = 16;
    localparam int unsigned HW            = 25;
    localparam int unsigned MIN_HZ        = 20;
    localparam int unsigned MAX_HZ        = 20000;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } tone_state_e;

endpackage

// File: rtl/tone_div.sv
// tone_div: serial restoring divider, constant dividend / variable divisor.
// Produces one quotient bit per cycle, MSB first; busy_o is high for exactly Q_W cycles.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   kill_i     synchronous abort of a running divide
//   start_i    begin a divide using divisor_i (ignored while busy)
//   divisor_i  divisor, must be nonzero
//   quot_o     quotient, valid while done_o is high
//   done_o     high during the last busy cycle
//   busy_o     divide in progress
module tone_div #(
    parameter int unsigned DIV_W    = tone_pkg::FREQ_W,
    parameter int unsigned Q_W      = tone_pkg::HW,
    parameter int unsigned DIVIDEND = tone_pkg::HALF_DIVIDEND
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic [Q_W-1:0]   quot_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned    IW       = $clog2(Q_W);
    localparam logic [Q_W-1:0] DVD      = Q_W'(DIVIDEND);
    localparam logic [IW-1:0]  LAST_IDX = IW'(Q_W - 1);

    logic             busy_q, busy_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic [Q_W-1:0]   quot_q, quot_d;

    logic [DIV_W:0]   trial;
    logic [DIV_W:0]   diff;
    logic             fits;
    logic [Q_W-1:0]   quot_step;

    always_comb begin
        // Bring down the next dividend bit; the remainder stays below the divisor,
        // so one extra bit is enough for the trial value.
        trial     = {rem_q, DVD[idx_q]};
        fits      = trial >= {1'b0, divisor_q};
        diff      = trial - {1'b0, divisor_q};
        quot_step = {quot_q[Q_W-2:0], fits};

        busy_d    = busy_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;

        if (kill_i) begin
            busy_d = 1'b0;
        end else if (start_i && !busy_q) begin
            busy_d    = 1'b1;
            idx_d     = LAST_IDX;
            rem_d     = '0;
            quot_d    = '0;
            divisor_d = divisor_i;
        end else if (busy_q) begin
            rem_d  = fits ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
            quot_d = quot_step;
            idx_d  = idx_q - IW'(1);
            if (idx_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= 1'b0;
            idx_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
        end else begin
            busy_q    <= busy_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
        end
    end

    assign quot_o = quot_step;
    assign done_o = busy_q && (idx_q == '0);
    assign busy_o = busy_q;

endmodule

// File: rtl/tone_gen.sv
// tone_gen: 50%-duty square-wave tone generator for the buzzer.
// The Hz request is converted to a half-period count by tone_div; a new count is
// applied only at a half-period boundary so the output never glitches.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   freq_i    requested tone in Hz, 0 = off
//   en_i      master enable, 0 = off
//   wave_o    square wave to the speaker
//   active_o  wave is running
//   busy_o    divider is computing
module tone_gen #(
    parameter int unsigned CLK_HZ = tone_pkg::CLK_HZ,
    parameter int unsigned FREQ_W = tone_pkg::FREQ_W,
    parameter int unsigned MIN_HZ = tone_pkg::MIN_HZ,
    parameter int unsigned MAX_HZ = tone_pkg::MAX_HZ,
    parameter int unsigned HW     = tone_pkg::HW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [FREQ_W-1:0] freq_i,
    input  logic              en_i,
    output logic              wave_o,
    output logic              active_o,
    output logic              busy_o
);

    import tone_pkg::*;

    localparam logic [FREQ_W-1:0] MIN_F = FREQ_W'(MIN_HZ);
    localparam logic [FREQ_W-1:0] MAX_F = FREQ_W'(MAX_HZ);

    tone_state_e       state_q, state_d;
    logic [FREQ_W-1:0] freq_lat_q, freq_lat_d;
    logic [HW-1:0]     half_q, half_d;
    logic [HW-1:0]     pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic [HW-1:0]     cnt_q, cnt_d;
    logic              wave_q, wave_d;

    logic [FREQ_W-1:0] req;
    logic              silence;
    logic              start;
    logic              div_done;
    logic              div_busy;
    logic [HW-1:0]     div_quot;

    assign req     = (en_i && freq_i >= MIN_F && freq_i <= MAX_F) ? freq_i : '0;
    assign silence = (req == '0);
    assign start   = !silence && (req != freq_lat_q) && !div_busy;

    tone_div #(
        .DIV_W    (FREQ_W),
        .Q_W      (HW),
        .DIVIDEND (CLK_HZ / 2)
    ) u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .kill_i    (silence),
        .start_i   (start),
        .divisor_i (req),
        .quot_o    (div_quot),
        .done_o    (div_done),
        .busy_o    (div_busy)
    );

    always_comb begin
        state_d      = state_q;
        freq_lat_d   = freq_lat_q;
        half_d       = half_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        wave_d       = wave_q;

        if (silence) begin
            state_d      = StIdle;
            wave_d       = 1'b0;
            freq_lat_d   = '0;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
        end else begin
            // A new divide makes any waiting result stale; drop it so an
            // out-of-date half-period is never played.
            if (start) begin
                freq_lat_d   = req;
                pend_valid_d = 1'b0;
            end
            if (div_done) begin
                pend_d       = div_quot;
                pend_valid_d = 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (pend_valid_q && !start) begin
                        half_d       = pend_q;
                        pend_valid_d = 1'b0;
                        cnt_d        = '0;
                        wave_d       = 1'b1;
                        state_d      = StRun;
                    end
                end
                StRun: begin
                    if (cnt_q == half_q - HW'(1)) begin
                        wave_d = ~wave_q;
                        cnt_d  = '0;
                        if (pend_valid_q && !start) begin
                            half_d       = pend_q;
                            pend_valid_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + HW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            freq_lat_q   <= '0;
            half_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            wave_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_lat_q   <= freq_lat_d;
            half_q       <= half_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            wave_q       <= wave_d;
        end
    end

    assign wave_o   = wave_q;
    assign active_o = (state_q == StRun);
    assign busy_o   = div_busy;

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: self-checking bench for tone_gen.
// Runs the design with a 1 MHz clock parameter so half-periods stay short
// (1000 Hz -> 500 cycles); expected half-periods come from (CLK_HZ/2)/f.
module tb_tone_gen;

    localparam int CLK_HZ = 1_000_000;
    localparam int HW     = 25;
    localparam int MIN_HZ = 20;
    localparam int MAX_HZ = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] freq;
    logic        en;
    logic        wave;
    logic        active;
    logic        busy;

    always #5 clk = ~clk;

    tone_gen #(
        .CLK_HZ (CLK_HZ),
        .FREQ_W (16),
        .MIN_HZ (MIN_HZ),
        .MAX_HZ (MAX_HZ),
        .HW     (HW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .freq_i   (freq),
        .en_i     (en),
        .wave_o   (wave),
        .active_o (active),
        .busy_o   (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Half-period lengths observed while the tone runs.
    int   ivals[$];
    int   last_t    = 0;
    bit   have_last = 1'b0;
    logic wave_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (active !== 1'b1) begin
            have_last = 1'b0;
        end else if (wave !== wave_prev) begin
            if (have_last) ivals.push_back(cyc - last_t);
            last_t    = cyc;
            have_last = 1'b1;
        end
        wave_prev = wave;
    end

    typedef struct {
        int freq;
        bit en;
        int exp_half;
    } vec_t;

    vec_t tbl[11];

    function automatic int model_half(input int f, input bit e);
        if (!e || f < MIN_HZ || f > MAX_HZ) return 0;
        return (CLK_HZ / 2) / f;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic silence();
        freq = '0;
        en   = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_active(input string name, input int limit, output int n);
        n = 0;
        while (active !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (active !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: active got 0 expected 1 within %0d cycles", name, limit);
        end
    endtask

    task automatic wait_ivals(input string name, input int cnt, input int limit);
        int n = 0;
        while (ivals.size() < cnt && n < limit) begin
            tick();
            n++;
        end
        if (ivals.size() < cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d half-periods expected %0d within %0d cycles",
                     name, ivals.size(), cnt, limit);
            while (ivals.size() < cnt) ivals.push_back(-1);
        end
    endtask

    // Waits for busy to rise, then counts the cycles it stays high.
    // Returns at the first sample with busy low again.
    task automatic count_busy(output int n);
        int w = 0;
        while (busy !== 1'b1 && w < 5) begin
            tick();
            w++;
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int f;
        int r;
        bit e;
        int exp;

        tbl[0]  = '{1396,  1'b1, 358};
        tbl[1]  = '{783,   1'b1, 638};
        tbl[2]  = '{1174,  1'b1, 425};
        tbl[3]  = '{2000,  1'b1, 250};
        tbl[4]  = '{20000, 1'b1, 25};
        tbl[5]  = '{0,     1'b1, 0};
        tbl[6]  = '{1000,  1'b0, 0};
        tbl[7]  = '{10,    1'b1, 0};
        tbl[8]  = '{25000, 1'b1, 0};
        tbl[9]  = '{19,    1'b1, 0};
        tbl[10] = '{20001, 1'b1, 0};

        // Reset state
        rst  = 1'b1;
        freq = '0;
        en   = 1'b0;
        tick();
        tick();
        tick();
        chk("reset_wave", 32'(wave), 0);
        chk("reset_active", 32'(active), 0);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // Basic tone
        freq = 16'd1000;
        en   = 1'b1;
        count_busy(n);
        chk("basic_busy_len", n, HW);
        chk("basic_idle_after_div", 32'(active), 0);
        tick();
        chk("basic_active", 32'(active), 1);
        chk("basic_wave_high", 32'(wave), 1);
        ivals.delete();
        wait_ivals("basic", 2, 1200);
        chk("basic_half0", ivals[0], 500);
        chk("basic_half1", ivals[1], 500);
        chk("basic_period", ivals[0] + ivals[1], 1000);

        // Table: retune from a running 1000 Hz tone, or drop into silence
        for (int i = 0; i < 11; i++) begin
            silence();
            freq = 16'd1000;
            en   = 1'b1;
            wait_active($sformatf("tbl%0d_base", i), HW + 8, n);
            ivals.delete();
            freq = 16'(tbl[i].freq);
            en   = tbl[i].en;
            if (tbl[i].exp_half == 0) begin
                tick();
                chk($sformatf("tbl%0d_wave", i), 32'(wave), 0);
                chk($sformatf("tbl%0d_active", i), 32'(active), 0);
            end else begin
                wait_ivals($sformatf("tbl%0d", i), 2, 1200);
                chk($sformatf("tbl%0d_old_half", i), ivals[0], 500);
                chk($sformatf("tbl%0d_new_half", i), ivals[1], tbl[i].exp_half);
            end
        end

        // Glitch-free retune mid half-period
        silence();
        freq = 16'd1000;
        wait_active("retune_base", HW + 8, n);
        repeat (200) tick();
        ivals.delete();
        freq = 16'd2000;
        wait_ivals("retune", 6, 2000);
        chk("retune_cur_half", ivals[0], 500);
        for (int k = 1; k < 6; k++) chk($sformatf("retune_half%0d", k), ivals[k], 250);

        // Change during divide: only the last request is ever played
        silence();
        ivals.delete();
        freq = 16'd1000;
        tick();
        tick();
        tick();
        freq = 16'd500;
        wait_active("chg", 2 * HW + 10, n);
        chk("chg_latency_ok", 32'(n + 3 <= 2 * HW + 4), 1);
        wait_ivals("chg", 2, 2200);
        chk("chg_half0", ivals[0], 1000);
        chk("chg_half1", ivals[1], 1000);

        // Reset mid-run, then reset mid-divide, then normal restart
        silence();
        freq = 16'd1000;
        wait_active("rstrun_base", HW + 8, n);
        repeat (200) tick();
        chk("rstrun_wave_before", 32'(wave), 1);
        rst = 1'b1;
        tick();
        chk("rstrun_wave", 32'(wave), 0);
        chk("rstrun_active", 32'(active), 0);
        chk("rstrun_busy", 32'(busy), 0);
        tick();
        chk("rst_hold_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (6) tick();
        chk("rstdiv_busy_before", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk("rstdiv_busy", 32'(busy), 0);
        chk("rstdiv_active", 32'(active), 0);
        rst = 1'b0;
        count_busy(n);
        chk("rstdiv_busy_len", n, HW);
        tick();
        chk("rstdiv_active_after", 32'(active), 1);
        chk("rstdiv_wave_after", 32'(wave), 1);
        ivals.delete();
        wait_ivals("rstdiv", 2, 1200);
        chk("rstdiv_half0", ivals[0], 500);
        chk("rstdiv_half1", ivals[1], 500);

        // Randomized requests against the reference model
        for (int it = 0; it < 8; it++) begin
            r = int'($urandom_range(0, 5));
            if (r == 0)      f = int'($urandom_range(0, 25));
            else if (r == 1) f = int'($urandom_range(19990, 20100));
            else             f = int'($urandom_range(400, 20000));
            e   = ($urandom_range(0, 7) != 0);
            exp = model_half(f, e);
            silence();
            ivals.delete();
            freq = 16'(f);
            en   = e;
            if (exp == 0) begin
                repeat (HW + 5) tick();
                chk($sformatf("rnd%0d_f%0d_active", it, f), 32'(active), 0);
                chk($sformatf("rnd%0d_f%0d_wave", it, f), 32'(wave), 0);
                chk($sformatf("rnd%0d_f%0d_busy", it, f), 32'(busy), 0);
            end else begin
                wait_active($sformatf("rnd%0d_f%0d", it, f), HW + 8, n);
                wait_ivals($sformatf("rnd%0d_f%0d", it, f), 2, 2 * exp + 20);
                chk($sformatf("rnd%0d_f%0d_half0", it, f), ivals[0], exp);
                chk($sformatf("rnd%0d_f%0d_half1", it, f), ivals[1], exp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Audio back end for the alarm/chime path: takes the 16-bit integer Hz request `freq` from the clock/alarm logic and produces a 50%-duty square wave for the buzzer pin.
- A serial restoring divider converts the Hz value to a half-period count in clock cycles.
- Frequency changes take effect only at a wave half-period boundary, so the output has no glitches.
- `freq`=0 means silence.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- FREQ_W, 16, width of the `freq` request.
- MIN_HZ, 20, lowest frequency played; a nonzero request below this is silence.
- MAX_HZ, 20000, highest frequency played; a request above this is silence.
- HW, 25, half-period / dividend width; must satisfy 2^HW > CLK_HZ/2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- freq  in  FREQ_W  requested tone in Hz; 0 = off.
- en  in  1  master enable; 0 forces silence like `freq`=0.
- wave  out  1  square wave to the speaker.
- active  out  1  high while the wave is running (state RUN).
- busy  out  1  high while the divider is computing.

Behaviour:
- Reset values (registered outputs, all reset synchronously):
  - wave=0, active=0, busy=0.
  - Internal: freq_lat=0, half=0, pend_valid=0, cnt=0, state=IDLE.
- Effective request: req = (en && freq>=MIN_HZ && freq<=MAX_HZ) ? freq : 0.
- Silence rule: when req==0, on the next clock edge:
  - wave=0, active=0, state=IDLE, freq_lat=0.
  - Any running divide is aborted (busy=0) and pend_valid=0.
- Change detect: in a cycle with req!=0, req!=freq_lat and busy==0:
  - freq_lat<=req and the divide starts; busy=1 from the next cycle.
- Divide:
  - Q = floor((CLK_HZ/2)/freq_lat), restoring algorithm, one quotient bit per cycle.
  - busy stays high exactly HW cycles.
  - On the last cycle: pend<=Q, pend_valid<=1, busy<=0.
- If req changes while busy, the change is ignored until done. It is detected on the first cycle after busy falls and triggers a new divide. The output always settles to the last stable request.
- IDLE + pend_valid: next cycle half<=pend, pend_valid<=0, cnt<=0, wave<=1, active<=1, state=RUN.
- RUN counting:
  - cnt increments each cycle.
  - When cnt==half-1: wave toggles, cnt<=0.
  - If pend_valid is set at that same edge, half<=pend and pend_valid<=0. The new period starts cleanly.
  - A pend arriving on the same edge as the terminal count is applied at the following terminal count, not the current one.
- Period check: wave period = 2*half cycles.
  - 1000 Hz → half=25000, period 50000 cycles (exactly 1 ms at 50 MHz).
- Width rules:
  - cnt and half are HW bits.
  - half>=1250 by construction, given the MAX_HZ range check.
- Reset mid-operation (RUN or busy) returns every register to its reset value within one cycle.

Decomposition:
- Package tone_pkg:
  - Constants: CLK_HZ, HALF_DIVIDEND = CLK_HZ/2, HW, MIN_HZ, MAX_HZ.
  - State enum {IDLE, RUN}.
- One sub-module, tone_div: serial restoring divider.
  - Inputs: clk, rst, start, divisor[FREQ_W].
  - Outputs: quot[HW], done (one-cycle pulse), busy.
  - The dividend is the HALF_DIVIDEND constant.
  - Abort on rst, or on a synchronous kill input driven by the silence rule.
- Top level contains the request qualification, the IDLE/RUN FSM, cnt/half/pend registers and the wave flop.

Test Plan:
- Basic tone: rst pulse, then freq=1000, en=1.
  - busy high 25 cycles, then active=1 and wave=1.
  - Toggles every 25000 cycles; measured period 50000 ±0.
- Truncation: freq=1396 → half=17908; freq=783 → half=31928; freq=1174 → half=21294. Check each via toggle interval.
- Glitch-free retune: freq 1000 → 2000 mid-half-period.
  - The current 25000-cycle half completes unchanged.
  - Subsequent halves are 12500 cycles.
  - No wave pulse shorter than 12500 cycles anywhere.
- Silence and range:
  - freq=0, en=0, freq=10 or freq=25000 → wave=0 and active=0 one cycle later.
  - Return to freq=1000 → wave restarts high after HW+1 cycles.
- Change during divide: freq=1000, then 3 cycles later freq=500.
  - After two divides (≤2*HW+2 cycles) half=50000.
  - No 25000-cycle half ever appears.
- Reset mid-run: assert rst while wave=1 and cnt≈10000 → next cycle wave=0, active=0, busy=0.
- Reset mid-divide: after rst is released with freq held at 1000, a fresh divide runs and the tone restarts normally.
